// File: rtl/uart_hex_loader_if.sv
// ---------------------------------------------------------------------------
// uart_hex_loader_if
//   Bundles the three byte/word streams the hex loader touches:
//     rx side  : rx_data, rx_rdy (from uart), rx_rdy_clr (to uart)
//     tx side  : tx_busy (from uart), tx_din, tx_wr_en (to uart)
//     mem side : mem_we, mem_addr, mem_wdata (to instruction memory)
//   master : the loader (drives rx_rdy_clr, tx_*, mem_*)
//   slave  : the surroundings (uart + instr_mem, or a testbench)
// ---------------------------------------------------------------------------
interface uart_hex_loader_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 4
);
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              rx_rdy_clr;
  logic              tx_busy;
  logic [7:0]        tx_din;
  logic              tx_wr_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    input  rx_data, rx_rdy, tx_busy,
    output rx_rdy_clr, tx_din, tx_wr_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_rdy, tx_busy,
    input  rx_rdy_clr, tx_din, tx_wr_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_hex_loader.sv
// ---------------------------------------------------------------------------
// uart_hex_loader
//   Pulls bytes from the uart receiver, parses ASCII hex text into WORD_W-bit
//   words (first character is the most significant nibble) and writes every
//   completed word to instruction memory at incrementing addresses. Each
//   accepted byte is optionally echoed back on the uart transmitter.
//
//   Ports
//     clk, rst      single clock, synchronous active-high reset
//     bus (master)  rx_data/rx_rdy/rx_rdy_clr, tx_busy/tx_din/tx_wr_en,
//                   mem_we/mem_addr/mem_wdata
//     word_count_o  words written since reset or 'R' (saturates at DEPTH)
//     nib_cnt_o     nibbles collected in the word being assembled
//     full_o        word_count_o == DEPTH
//     overflow_o    sticky: a completed word was dropped because full
//     bad_char_o    sticky: an unrecognised byte was received
//     partial_o     sticky: a separator arrived mid-word
//
//   Byte classes: hex digit (either case), separator (space, LF, CR, comma),
//   'R'/'r' (rewind to address 0), anything else (flagged, ignored).
// ---------------------------------------------------------------------------
module uart_hex_loader #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 4,
  parameter int ECHO   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_hex_loader_if.master             bus,
  output logic [ADDR_W:0]               word_count_o,
  output logic [$clog2(WORD_W/4):0]     nib_cnt_o,
  output logic                          full_o,
  output logic                          overflow_o,
  output logic                          bad_char_o,
  output logic                          partial_o
);

  localparam int NIB   = WORD_W / 4;
  localparam int NCW   = $clog2(NIB) + 1;
  localparam int WCW   = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  // {valid, nibble} for an ASCII hex digit; valid=0 for any other byte.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0_0000;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'b0_0000;
    end
    return r;
  endfunction

  // Word terminators: space, LF, CR, comma.
  function automatic logic is_sep(input logic [7:0] c);
    logic r;
    case (c)
      8'h20, 8'h0A, 8'h0D, 8'h2C: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  // Rewind command: 'R' or 'r'.
  function automatic logic is_rewind(input logic [7:0] c);
    logic r;
    case (c)
      8'h52, 8'h72: r = 1'b1;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

  state_t            state_q;
  logic [7:0]        byte_q;
  logic [WORD_W-1:0] acc_q;
  logic [NCW-1:0]    nib_cnt_q;
  logic [ADDR_W-1:0] addr_q;       // next write address (pointer)
  logic [WCW-1:0]    word_count_q;
  logic              full_q;
  logic              overflow_q;
  logic              bad_char_q;
  logic              partial_q;
  logic              rx_rdy_clr_q;
  logic              tx_wr_en_q;
  logic [7:0]        tx_din_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;   // address presented with mem_we
  logic [WORD_W-1:0] mem_wdata_q;

  logic [4:0]        dec_s;
  logic              hex_hit_s;
  logic [3:0]        hex_nib_s;

  // Classify the captured byte; only consumed in DECODE.
  always_comb begin
    dec_s     = hex_decode(byte_q);
    hex_hit_s = dec_s[4];
    hex_nib_s = dec_s[3:0];
  end

  // Loader FSM with all outputs registered. Strobes default low each cycle so
  // none of them can stay high for two consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_q       <= 8'h00;
      acc_q        <= '0;
      nib_cnt_q    <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      bad_char_q   <= 1'b0;
      partial_q    <= 1'b0;
      rx_rdy_clr_q <= 1'b0;
      tx_wr_en_q   <= 1'b0;
      tx_din_q     <= 8'h00;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      rx_rdy_clr_q <= 1'b0;
      tx_wr_en_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A pending byte waits while the transmitter is busy so the echo
          // can never be lost.
          if (bus.rx_rdy && !bus.tx_busy) begin
            byte_q       <= bus.rx_data;
            rx_rdy_clr_q <= 1'b1;
            tx_wr_en_q   <= (ECHO != 0);
            tx_din_q     <= bus.rx_data;
            state_q      <= S_DECODE;
          end else begin
            state_q      <= S_IDLE;
          end
        end

        S_DECODE: begin
          state_q <= S_IDLE;
          if (hex_hit_s) begin
            acc_q     <= {acc_q[WORD_W-5:0], hex_nib_s};
            nib_cnt_q <= nib_cnt_q + NCW'(1);
            if (nib_cnt_q == NCW'(NIB - 1)) begin
              state_q <= S_WRITE;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (is_sep(byte_q)) begin
            if (nib_cnt_q != NCW'(0)) begin
              partial_q <= 1'b1;
              acc_q     <= '0;
              nib_cnt_q <= '0;
            end else begin
              partial_q <= partial_q;
            end
          end else if (is_rewind(byte_q)) begin
            addr_q       <= '0;
            word_count_q <= '0;
            full_q       <= 1'b0;
            nib_cnt_q    <= '0;
            acc_q        <= '0;
          end else begin
            bad_char_q <= 1'b1;
          end
        end

        S_WRITE: begin
          if (!full_q) begin
            mem_we_q     <= 1'b1;
            mem_wdata_q  <= acc_q;
            mem_addr_q   <= addr_q;
            addr_q       <= addr_q + ADDR_W'(1);   // wraps at DEPTH
            word_count_q <= word_count_q + WCW'(1);
            full_q       <= (word_count_q == WCW'(DEPTH - 1));
          end else begin
            overflow_q   <= 1'b1;
          end
          nib_cnt_q <= '0;
          state_q   <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_rdy_clr = rx_rdy_clr_q;
  assign bus.tx_wr_en   = tx_wr_en_q;
  assign bus.tx_din     = tx_din_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  assign word_count_o = word_count_q;
  assign nib_cnt_o    = nib_cnt_q;
  assign full_o       = full_q;
  assign overflow_o   = overflow_q;
  assign bad_char_o   = bad_char_q;
  assign partial_o    = partial_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Testbench for uart_hex_loader: table-driven text vectors, hand-written
// corner sequences and a randomized byte stream against a reference model.
module tb_uart_hex_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_hex_loader_if #(.WORD_W(32), .ADDR_W(4)) bus ();

  logic [4:0] word_count;
  logic [3:0] nib_cnt;
  logic       full, overflow, bad_char, partial;

  uart_hex_loader #(.WORD_W(32), .ADDR_W(4), .ECHO(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .word_count_o (word_count),
    .nib_cnt_o    (nib_cnt),
    .full_o       (full),
    .overflow_o   (overflow),
    .bad_char_o   (bad_char),
    .partial_o    (partial)
  );

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] echo_q[$];
  logic [7:0] sent_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pulse_err = 0;
  logic       prev_we = 1'b0, prev_clr = 1'b0, prev_tx = 1'b0;

  // Monitor: record memory writes and echoes, flag strobes wider than one cycle.
  always @(negedge clk) begin
    if (bus.mem_we) wr_q.push_back('{bus.mem_addr, bus.mem_wdata});
    if (bus.tx_wr_en) echo_q.push_back(bus.tx_din);
    if ((bus.mem_we && prev_we) || (bus.rx_rdy_clr && prev_clr) || (bus.tx_wr_en && prev_tx))
      pulse_err <= pulse_err + 1;
    prev_we  <= bus.mem_we;
    prev_clr <= bus.rx_rdy_clr;
    prev_tx  <= bus.tx_wr_en;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    bus.tx_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    sent_q.push_back(b);
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      if (bus.rx_rdy_clr) done = 1;
    end
    bus.rx_rdy = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h not consumed, required rx_rdy_clr", b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int         m_nib, m_cnt;
  logic [31:0] m_acc;
  bit         m_part, m_bad, m_ovf;
  wr_t        exp_q[$];

  function automatic void model_reset();
    m_nib = 0; m_cnt = 0; m_acc = 0;
    m_part = 0; m_bad = 0; m_ovf = 0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] c);
    string digits = "0123456789abcdef";
    string seps   = " \n\r,";
    logic [7:0] lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    int idx = -1;
    bit sep = 0;
    for (int i = 0; i < 16; i++) if (digits[i] == lc) idx = i;
    for (int i = 0; i < 4; i++) if (seps[i] == c) sep = 1;
    if (idx >= 0) begin
      m_acc = (m_acc << 4) | 32'(idx);
      m_nib++;
      if (m_nib == 8) begin
        if (m_cnt < 16) begin
          exp_q.push_back('{4'(m_cnt), m_acc});
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
        m_nib = 0;
      end
    end else if (sep) begin
      if (m_nib != 0) m_part = 1;
      m_nib = 0; m_acc = 0;
    end else if (lc == "r") begin
      m_cnt = 0; m_nib = 0; m_acc = 0;
    end else begin
      m_bad = 1;
    end
  endfunction

  typedef struct {
    string       txt;
    int          n_wr;
    logic [3:0]  la;
    logic [31:0] ld;
    int          wc;
    int          nib;
    bit          part, bad, ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int w0, e0, s0, mism;
    string alpha_hex = "0123456789abcdefABCDEF";
    string alpha_sep = " \n\r,";
    string alpha_bad = "GxZ!@q";

    vecs[0] = '{"00500093",             1, 4'd0, 32'h00500093, 1, 0, 0, 0, 0};
    vecs[1] = '{"deadBEEF\n",           1, 4'd0, 32'hDEADBEEF, 1, 0, 0, 0, 0};
    vecs[2] = '{"12G34\n",              0, 4'd0, 32'h0,        0, 0, 1, 1, 0};
    vecs[3] = '{"1234",                 0, 4'd0, 32'h0,        0, 4, 0, 0, 0};
    vecs[4] = '{"abcdef01,R",           1, 4'd0, 32'hABCDEF01, 0, 0, 0, 0, 0};
    vecs[5] = '{"12345678 9abcdef0\r",  2, 4'd1, 32'h9ABCDEF0, 2, 0, 0, 0, 0};
    vecs[6] = '{"5a, 7",                0, 4'd0, 32'h0,        0, 1, 1, 0, 0};

    // Reset state
    do_reset();
    chk("reset_outputs",
        64'({bus.rx_rdy_clr, bus.tx_wr_en, bus.tx_din, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, word_count, nib_cnt, full, overflow, bad_char, partial}), 64'h0);

    // Table-driven text vectors
    for (int v = 0; v < 7; v++) begin
      do_reset();
      w0 = wr_q.size(); e0 = echo_q.size(); s0 = sent_q.size();
      send_str(vecs[v].txt);
      settle();
      chk($sformatf("v%0d_n_writes", v), wr_q.size() - w0, vecs[v].n_wr);
      if (vecs[v].n_wr > 0 && wr_q.size() > 0) begin
        chk($sformatf("v%0d_last_addr", v), wr_q[wr_q.size()-1].a, vecs[v].la);
        chk($sformatf("v%0d_last_data", v), wr_q[wr_q.size()-1].d, vecs[v].ld);
      end
      chk($sformatf("v%0d_word_count", v), word_count, vecs[v].wc);
      chk($sformatf("v%0d_nib_cnt", v), nib_cnt, vecs[v].nib);
      chk($sformatf("v%0d_flags", v), {partial, bad_char, overflow, full},
          {vecs[v].part, vecs[v].bad, vecs[v].ovf, 1'b0});
      chk($sformatf("v%0d_echo_count", v), echo_q.size() - e0, vecs[v].txt.len());
      mism = 0;
      for (int i = 0; i < vecs[v].txt.len() && e0 + i < echo_q.size(); i++)
        if (echo_q[e0 + i] !== sent_q[s0 + i]) mism++;
      chk($sformatf("v%0d_echo_bytes", v), mism, 0);
    end

    // 17 words: 16 written, 17th dropped
    do_reset();
    w0 = wr_q.size();
    for (int i = 0; i < 16; i++) send_str($sformatf("%08x", 32'h1000_0000 + 32'(i * 3)));
    settle();
    chk("full_after16", {full, overflow, word_count}, {1'b1, 1'b0, 5'd16});
    send_str("ffffffff");
    settle();
    chk("fill_n_writes", wr_q.size() - w0, 16);
    mism = 0;
    for (int i = 0; i < 16 && w0 + i < wr_q.size(); i++)
      if (wr_q[w0 + i].a !== 4'(i) || wr_q[w0 + i].d !== 32'h1000_0000 + 32'(i * 3)) mism++;
    chk("fill_addr_data", mism, 0);
    chk("overflow_after17", {full, overflow, word_count}, {1'b1, 1'b1, 5'd16});

    // Rewind, then tx_busy holds off the next byte
    do_reset();
    w0 = wr_q.size();
    send_str("11111111 22222222 33333333 R");
    settle();
    chk("rewind_count", word_count, 0);
    bus.tx_busy = 1'b1;
    bus.rx_data = "0";
    bus.rx_rdy  = 1'b1;
    mism = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.rx_rdy_clr) mism++;
    end
    chk("busy_holds_rx", mism, 0);
    bus.tx_busy = 1'b0;
    send_byte("0");
    send_str("000006F");
    settle();
    chk("rewind_n_writes", wr_q.size() - w0, 4);
    if (wr_q.size() > 0) begin
      chk("rewind_addr", wr_q[wr_q.size()-1].a, 4'd0);
      chk("rewind_data", wr_q[wr_q.size()-1].d, 32'h0000006F);
    end
    chk("rewind_wc", word_count, 1);

    // Reset mid-word
    do_reset();
    send_str("12345");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_outputs",
        64'({bus.rx_rdy_clr, bus.tx_wr_en, bus.tx_din, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, word_count, nib_cnt, full, overflow, bad_char, partial}), 64'h0);
    rst = 1'b0;
    w0 = wr_q.size();
    send_str("cafef00d");
    settle();
    chk("midreset_n_writes", wr_q.size() - w0, 1);
    if (wr_q.size() > w0) begin
      chk("midreset_addr", wr_q[w0].a, 4'd0);
      chk("midreset_data", wr_q[w0].d, 32'hCAFEF00D);
    end

    // Randomized stream against the reference model
    do_reset();
    model_reset();
    w0 = wr_q.size();
    for (int n = 0; n < 600; n++) begin
      int r = $urandom_range(0, 99);
      logic [7:0] c;
      if (r < 92)      c = alpha_hex[$urandom_range(0, 21)];
      else if (r < 96) c = alpha_sep[$urandom_range(0, 3)];
      else if (r < 97) c = ($urandom_range(0, 1) != 0) ? 8'h52 : 8'h72;
      else             c = alpha_bad[$urandom_range(0, 5)];
      send_byte(c);
      model_byte(c);
      if (n % 50 == 49) begin
        settle();
        chk($sformatf("rnd%0d_state", n), {word_count, nib_cnt, full},
            {5'(m_cnt), 4'(m_nib), (m_cnt == 16)});
        chk($sformatf("rnd%0d_flags", n), {partial, bad_char, overflow}, {m_part, m_bad, m_ovf});
      end
    end
    settle();
    chk("rnd_n_writes", wr_q.size() - w0, exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && w0 + i < wr_q.size(); i++)
      if (wr_q[w0 + i].a !== exp_q[i].a || wr_q[w0 + i].d !== exp_q[i].d) mism++;
    chk("rnd_writes", mism, 0);

    chk("strobe_width", pulse_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
